// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text buffer.
package text_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 16;
    localparam int CELL_AW   = 8;
    localparam int FONT_AW   = 11;

    localparam logic [7:0] DEF_CLEAR_CODE = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/font_rom.sv
// 2048x8 synchronous glyph ROM, address {code[6:0], line[3:0]}, registered output.
// The glyph set is defined inline so the ROM synthesizes without a memory init file.
module font_rom
    import text_pkg::*;
(
    input  logic               pclk,
    input  logic               rst,
    input  logic [FONT_AW-1:0] addr,
    input  logic               blank,
    output logic [CHAR_W-1:0]  data
);

    // Space is blank, 'A' is a real glyph, other codes get a {line, code[3:0]} test pattern.
    function automatic logic [CHAR_W-1:0] glyph_row(input logic [6:0] code,
                                                     input logic [3:0] line);
        logic [CHAR_W-1:0] row;
        row = {line, code[3:0]};
        if (code == 7'h20) begin
            row = 8'h00;
        end else if (code == 7'h41) begin
            case (line)
                4'd2:                            row = 8'h10;
                4'd3:                            row = 8'h38;
                4'd4:                            row = 8'h6C;
                4'd5, 4'd6, 4'd8, 4'd9,
                4'd10, 4'd11:                    row = 8'hC6;
                4'd7:                            row = 8'hFE;
                default:                         row = 8'h00;
            endcase
        end
        return row;
    endfunction

    always_ff @(posedge pclk) begin
        if (rst || blank) begin
            data <= '0;
        end else begin
            data <= glyph_row(addr[FONT_AW-1:4], addr[3:0]);
        end
    end

endmodule

// File: rtl/text_char_buffer.sv
// 16x16 character-code buffer with bulk-clear sequencer and 2-cycle glyph lookup.
// Optional blink attribute (code bit 7) is built when TEXT_BLINK_EN is defined.
module text_char_buffer
    import text_pkg::*;
#(
    parameter int         BLINK_FRAMES = 32,
    parameter logic [7:0] CLEAR_CODE   = DEF_CLEAR_CODE
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [CELL_AW-1:0] char_xy,
    input  logic [3:0]         char_line,
    input  logic               vsync_in,
    output logic [CHAR_W-1:0]  char_pixels,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [CELL_AW-1:0] wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               clr_req,
    output logic               busy
);

    state_t             state;
    logic [CELL_AW-1:0] clr_cnt;
    logic               ram_we;
    logic [CELL_AW-1:0] ram_waddr;
    logic [7:0]         ram_wdata;
    logic [7:0]         code_ram [2**CELL_AW];
    logic [7:0]         code_q;
    logic [3:0]         line_q;
    logic               vsync_d;
    logic               frame_tick;
    logic               blank;

    assign busy     = rst || (state == ST_CLEAR);
    assign wr_ready = !rst && (state == ST_IDLE) && !clr_req;

    assign ram_we    = (state == ST_CLEAR) || (wr_valid && wr_ready);
    assign ram_waddr = (state == ST_CLEAR) ? clr_cnt : wr_addr;
    assign ram_wdata = (state == ST_CLEAR) ? CLEAR_CODE : wr_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // NOTE: the code RAM has no reset; the clear sequencer initialises it after every reset.
    always_ff @(posedge pclk) begin
        if (ram_we) begin
            code_ram[ram_waddr] <= ram_wdata;
        end
    end

    // Stage 1: read-first lookup of the cell code alongside its glyph line.
    always_ff @(posedge pclk) begin
        if (rst) begin
            code_q  <= '0;
            line_q  <= '0;
            vsync_d <= 1'b0;
        end else begin
            code_q  <= code_ram[char_xy];
            line_q  <= char_line;
            vsync_d <= vsync_in;
        end
    end

    assign frame_tick = vsync_in && !vsync_d;

`ifdef TEXT_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blank = code_q[7] && blink_phase;
`else
    logic unused_blink;

    assign blank        = 1'b0;
    assign unused_blink = &{1'b0, code_q[7], frame_tick, BLINK_FRAMES[0]};
`endif

    // Stage 2 lives in the ROM output register.
    font_rom u_font_rom (
        .pclk  (pclk),
        .rst   (rst),
        .addr  ({code_q[6:0], line_q}),
        .blank (blank),
        .data  (char_pixels)
    );

endmodule

// File: tb/tb_text_char_buffer.sv
// Directed self-checking bench for text_char_buffer; blink expectations follow TEXT_BLINK_EN.
module tb_text_char_buffer;

`ifdef TEXT_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       pclk;
    logic       rst;
    logic [7:0] char_xy;
    logic [3:0] char_line;
    logic       vsync_in;
    logic [7:0] char_pixels;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_req;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_char_buffer #(
        .BLINK_FRAMES (2),
        .CLEAR_CODE   (8'h20)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .char_xy     (char_xy),
        .char_line   (char_line),
        .vsync_in    (vsync_in),
        .char_pixels (char_pixels),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_req     (clr_req),
        .busy        (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts consecutive cycles with busy high, starting with the current cycle.
    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            n++;
            @(negedge pclk);
            #1;
        end
        check(tag, n, 256);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        int n;
        @(negedge pclk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        #1;
        n = 0;
        while (!wr_ready && n < 300) begin
            n++;
            @(negedge pclk);
            #1;
        end
        if (!wr_ready) check("wr_timeout", 0, 1);
        @(posedge pclk);
        @(negedge pclk);
        wr_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] xy, input logic [3:0] line,
                              input logic [7:0] exp);
        @(negedge pclk);
        char_xy   = xy;
        char_line = line;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        check(tag, char_pixels, exp);
    endtask

    task automatic pulse_vsync();
        @(negedge pclk);
        vsync_in = 1'b1;
        repeat (2) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        rst       = 1'b1;
        char_xy   = '0;
        char_line = '0;
        vsync_in  = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_req   = 1'b0;
        repeat (3) @(negedge pclk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_ready", wr_ready, 0);
        check("rst_pixels", char_pixels, 8'h00);

        // Power-up clear
        @(negedge pclk);
        rst = 1'b0;
        #1;
        count_busy("init_clear_len");
        check("idle_ready", wr_ready, 1);
        read_check("space_00", 8'h00, 4'd0, 8'h00);
        read_check("space_7f", 8'h7F, 4'd9, 8'h00);
        read_check("space_ff", 8'hFF, 4'd15, 8'h00);

        // Basic writes and glyph lookup
        do_write(8'h23, 8'h41);
        read_check("A_line5", 8'h23, 4'd5, 8'hC6);
        read_check("A_line2", 8'h23, 4'd2, 8'h10);
        do_write(8'h45, 8'h5A);
        read_check("pat_5a_l3", 8'h45, 4'd3, 8'h3A);
        do_write(8'h46, 8'hC1);
        read_check("blink_A_vis", 8'h46, 4'd7, 8'hFE);

        // Read presented the cycle after acceptance sees the new code
        @(negedge pclk);
        wr_valid = 1'b1; wr_addr = 8'h50; wr_data = 8'h5A;
        @(negedge pclk);
        wr_valid = 1'b0; char_xy = 8'h50; char_line = 4'd4;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        check("wr_then_rd", char_pixels, 8'h4A);

        // Same-cycle read and write to 8'h10: old data then new data
        @(negedge pclk);
        wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 8'h41;
        char_xy = 8'h10; char_line = 4'd5;
        @(negedge pclk);
        wr_valid = 1'b0;
        @(negedge pclk);
        check("rw_same_old", char_pixels, 8'h00);
        @(negedge pclk);
        check("rw_next_new", char_pixels, 8'hC6);

        // Blink
        pulse_vsync();
        pulse_vsync();
        read_check("blink_half1", 8'h46, 4'd7, BLINK_ON ? 8'h00 : 8'hFE);
        read_check("blink_noattr", 8'h23, 4'd7, 8'hFE);
        pulse_vsync();
        pulse_vsync();
        read_check("blink_half2", 8'h46, 4'd7, 8'hFE);

        // Clear request beats a same-cycle write
        do_write(8'h30, 8'h5A);
        read_check("pre_clr_30", 8'h30, 4'd3, 8'h3A);
        @(negedge pclk);
        wr_valid = 1'b1; wr_addr = 8'h30; wr_data = 8'h41; clr_req = 1'b1;
        #1;
        check("clr_blocks_ready", wr_ready, 0);
        @(negedge pclk);
        wr_valid = 1'b0; clr_req = 1'b0;
        #1;
        count_busy("req_clear_len");
        read_check("post_clr_30", 8'h30, 4'd5, 8'h00);
        read_check("post_clr_23", 8'h23, 4'd5, 8'h00);

        // Reset when the clear counter reaches 100
        do_write(8'hC8, 8'h41);
        do_write(8'hFF, 8'h41);
        read_check("pre_rst_ff", 8'hFF, 4'd5, 8'hC6);
        @(negedge pclk);
        clr_req = 1'b1;
        @(negedge pclk);
        clr_req = 1'b0;
        repeat (100) @(negedge pclk);
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        #1;
        count_busy("midrst_clear_len");
        for (int a = 0; a < 256; a++) begin
            read_check($sformatf("midrst_cell_%0h", a), 8'(a), 4'd5, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
